biu_line_arbiter: RTL and testbench

Two-requester arbiter between the I-cache and D-cache refill/writeback ports and the single cache-line port of the bus interface unit. It accepts one line request at a time using round-robin grant and forwards it to the BIU with the address aligned to the line size. It captures the BIU's single-cycle response pulse into a buffer and returns that response to the owning requester under a valid/ready handshake. Only one transaction is ever outstanding.

---
 rtl/biu_line_arbiter.sv | 140 ++++++++++++++
 tb/tb_biu_line_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/biu_line_arbiter.sv
// Round-robin arbiter between the I-cache and D-cache line ports and the single BIU cache-line port.
// One transaction is outstanding at a time; the BIU response pulse is buffered and handed back under valid/ready.
module biu_line_arbiter #(
  parameter int ADDR_W   = 64,
  parameter int LINE_W   = 512,
  parameter int OFFSET_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_req_vld_i,
  output logic              ic_req_rdy_o,
  input  logic              ic_req_rd_i,
  input  logic [ADDR_W-1:0] ic_req_addr_i,
  input  logic [LINE_W-1:0] ic_req_wdata_i,
  output logic              ic_resp_vld_o,
  input  logic              ic_resp_rdy_i,
  output logic [LINE_W-1:0] ic_resp_rdata_o,
  output logic              ic_resp_err_o,
  input  logic              dc_req_vld_i,
  output logic              dc_req_rdy_o,
  input  logic              dc_req_rd_i,
  input  logic [ADDR_W-1:0] dc_req_addr_i,
  input  logic [LINE_W-1:0] dc_req_wdata_i,
  output logic              dc_resp_vld_o,
  input  logic              dc_resp_rdy_i,
  output logic [LINE_W-1:0] dc_resp_rdata_o,
  output logic              dc_resp_err_o,
  output logic              biu_req_vld_o,
  input  logic              biu_req_rdy_i,
  output logic              biu_req_rd_o,
  output logic [ADDR_W-1:0] biu_req_addr_o,
  output logic [LINE_W-1:0] biu_req_wdata_o,
  input  logic              biu_resp_vld_i,
  output logic              biu_resp_rdy_o,
  input  logic [LINE_W-1:0] biu_resp_rdata_i,
  input  logic              biu_resp_err_i,
  output logic              busy_o,
  output logic              owner_o,
  output logic              spurious_resp_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFFSET_W) - ADDR_W'(1));

  state_t            state, state_next;
  logic              rr;
  logic              owner;
  logic              ic_win, dc_win, accept;
  logic              owner_resp_rdy;
  logic              lat_rd;
  logic [ADDR_W-1:0] lat_addr;
  logic [LINE_W-1:0] lat_wdata;
  logic [LINE_W-1:0] buf_rdata;
  logic              buf_err;
  logic              spurious;

  // rr names the requester that wins a tie: 0 = IC, 1 = DC.
  always_comb begin
    ic_win = ic_req_vld_i & (~dc_req_vld_i | ~rr);
    dc_win = dc_req_vld_i & (~ic_req_vld_i | rr);
    accept = (state == IDLE) & (ic_req_vld_i | dc_req_vld_i);
    owner_resp_rdy = owner ? dc_resp_rdy_i : ic_resp_rdy_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    ic_req_rdy_o   = 1'b0;
    dc_req_rdy_o   = 1'b0;
    biu_req_vld_o  = 1'b0;
    biu_resp_rdy_o = 1'b0;
    ic_resp_vld_o  = 1'b0;
    dc_resp_vld_o  = 1'b0;
    unique case (state)
      IDLE: begin
        ic_req_rdy_o = ic_win;
        dc_req_rdy_o = dc_win;
        if (accept) state_next = ISSUE;
      end
      ISSUE: begin
        biu_req_vld_o = 1'b1;
        if (biu_req_rdy_i) state_next = WAIT;
      end
      WAIT: begin
        biu_resp_rdy_o = 1'b1;
        if (biu_resp_vld_i) state_next = RESP;
      end
      RESP: begin
        ic_resp_vld_o = ~owner;
        dc_resp_vld_o = owner;
        if (owner_resp_rdy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, response buffer and arbitration bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr        <= 1'b1;
      owner     <= 1'b0;
      lat_rd    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      buf_rdata <= '0;
      buf_err   <= 1'b0;
      spurious  <= 1'b0;
    end else begin
      if (accept) begin
        owner     <= dc_win;
        rr        <= ~dc_win;
        lat_rd    <= dc_win ? dc_req_rd_i : ic_req_rd_i;
        lat_addr  <= (dc_win ? dc_req_addr_i : ic_req_addr_i) & ADDR_MASK;
        lat_wdata <= dc_win ? dc_req_wdata_i : ic_req_wdata_i;
      end
      if (state == WAIT && biu_resp_vld_i) begin
        buf_rdata <= biu_resp_rdata_i;
        buf_err   <= biu_resp_err_i;
      end
      if (state != WAIT && biu_resp_vld_i) spurious <= 1'b1;
    end
  end

  assign biu_req_rd_o    = lat_rd;
  assign biu_req_addr_o  = lat_addr;
  assign biu_req_wdata_o = lat_wdata;
  assign ic_resp_rdata_o = buf_rdata;
  assign dc_resp_rdata_o = buf_rdata;
  assign ic_resp_err_o   = buf_err;
  assign dc_resp_err_o   = buf_err;
  assign busy_o          = (state != IDLE);
  assign owner_o         = owner;
  assign spurious_resp_o = spurious;

endmodule

// File: tb/tb_biu_line_arbiter.sv
// Self-checking bench for biu_line_arbiter: directed transactions push expectations into queues,
// and a negedge monitor pops and compares at each BIU request and requester response handshake.
module tb_biu_line_arbiter;

  typedef struct packed {
    logic         rd;
    logic [63:0]  addr;
    logic [511:0] wdata;
  } req_t;

  typedef struct packed {
    logic         owner;
    logic [511:0] rdata;
    logic         err;
  } resp_t;

  logic         clk, rst_n;
  logic         ic_req_vld_i, ic_req_rdy_o, ic_req_rd_i;
  logic [63:0]  ic_req_addr_i;
  logic [511:0] ic_req_wdata_i;
  logic         ic_resp_vld_o, ic_resp_rdy_i, ic_resp_err_o;
  logic [511:0] ic_resp_rdata_o;
  logic         dc_req_vld_i, dc_req_rdy_o, dc_req_rd_i;
  logic [63:0]  dc_req_addr_i;
  logic [511:0] dc_req_wdata_i;
  logic         dc_resp_vld_o, dc_resp_rdy_i, dc_resp_err_o;
  logic [511:0] dc_resp_rdata_o;
  logic         biu_req_vld_o, biu_req_rdy_i, biu_req_rd_o;
  logic [63:0]  biu_req_addr_o;
  logic [511:0] biu_req_wdata_o;
  logic         biu_resp_vld_i, biu_resp_rdy_o, biu_resp_err_i;
  logic [511:0] biu_resp_rdata_i;
  logic         busy_o, owner_o, spurious_resp_o;

  int total = 0;
  int bad   = 0;
  req_t  exp_req[$];
  resp_t exp_resp[$];

  biu_line_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .ic_req_vld_i(ic_req_vld_i), .ic_req_rdy_o(ic_req_rdy_o), .ic_req_rd_i(ic_req_rd_i),
    .ic_req_addr_i(ic_req_addr_i), .ic_req_wdata_i(ic_req_wdata_i),
    .ic_resp_vld_o(ic_resp_vld_o), .ic_resp_rdy_i(ic_resp_rdy_i),
    .ic_resp_rdata_o(ic_resp_rdata_o), .ic_resp_err_o(ic_resp_err_o),
    .dc_req_vld_i(dc_req_vld_i), .dc_req_rdy_o(dc_req_rdy_o), .dc_req_rd_i(dc_req_rd_i),
    .dc_req_addr_i(dc_req_addr_i), .dc_req_wdata_i(dc_req_wdata_i),
    .dc_resp_vld_o(dc_resp_vld_o), .dc_resp_rdy_i(dc_resp_rdy_i),
    .dc_resp_rdata_o(dc_resp_rdata_o), .dc_resp_err_o(dc_resp_err_o),
    .biu_req_vld_o(biu_req_vld_o), .biu_req_rdy_i(biu_req_rdy_i), .biu_req_rd_o(biu_req_rd_o),
    .biu_req_addr_o(biu_req_addr_o), .biu_req_wdata_o(biu_req_wdata_o),
    .biu_resp_vld_i(biu_resp_vld_i), .biu_resp_rdy_o(biu_resp_rdy_o),
    .biu_resp_rdata_i(biu_resp_rdata_i), .biu_resp_err_i(biu_resp_err_i),
    .busy_o(busy_o), .owner_o(owner_o), .spurious_resp_o(spurious_resp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares at handshakes, sampled on the falling edge.
  initial begin
    req_t  r;
    resp_t e;
    forever begin
      @(negedge clk);
      if (biu_req_vld_o && biu_req_rdy_i) begin
        if (exp_req.size() == 0) checkOutput("unexpected biu req", 512'(1), 512'(0));
        else begin
          r = exp_req.pop_front();
          checkOutput("biu_req_rd", 512'(biu_req_rd_o), 512'(r.rd));
          checkOutput("biu_req_addr", 512'(biu_req_addr_o), 512'(r.addr));
          checkOutput("biu_req_wdata", biu_req_wdata_o, r.wdata);
        end
      end
      if ((ic_resp_vld_o && ic_resp_rdy_i) || (dc_resp_vld_o && dc_resp_rdy_i)) begin
        if (exp_resp.size() == 0) checkOutput("unexpected resp", 512'(1), 512'(0));
        else begin
          e = exp_resp.pop_front();
          checkOutput("resp owner", 512'(dc_resp_vld_o), 512'(e.owner));
          checkOutput("resp rdata", e.owner ? dc_resp_rdata_o : ic_resp_rdata_o, e.rdata);
          checkOutput("resp err", 512'(e.owner ? dc_resp_err_o : ic_resp_err_o), 512'(e.err));
        end
      end
    end
  end

  // Drives the BIU and the owner's response side after an accept; checks stability while stalled.
  task automatic serve(input logic own, input logic rd, input logic [63:0] addr, input logic [511:0] wdata,
                       input logic [511:0] rdata, input logic err, input int biu_wait, input int resp_wait);
    for (int i = 0; i < biu_wait; i++) begin
      checkOutput("stall biu_req_vld", 512'(biu_req_vld_o), 512'(1));
      checkOutput("stall biu_req_rd", 512'(biu_req_rd_o), 512'(rd));
      checkOutput("stall biu_req_addr", 512'(biu_req_addr_o), 512'(addr));
      checkOutput("stall biu_req_wdata", biu_req_wdata_o, wdata);
      checkOutput("stall req_rdy", 512'({ic_req_rdy_o, dc_req_rdy_o}), 512'(0));
      tick();
    end
    checkOutput("issue biu_req_vld", 512'(biu_req_vld_o), 512'(1));
    biu_req_rdy_i = 1'b1;
    tick();
    biu_req_rdy_i = 1'b0;
    checkOutput("wait biu_resp_rdy", 512'(biu_resp_rdy_o), 512'(1));
    biu_resp_vld_i = 1'b1;
    biu_resp_rdata_i = rdata;
    biu_resp_err_i = err;
    tick();
    biu_resp_vld_i = 1'b0;
    biu_resp_rdata_i = '0;
    biu_resp_err_i = 1'b0;
    checkOutput("resp vld latency", 512'({ic_resp_vld_o, dc_resp_vld_o}), own ? 512'(1) : 512'(2));
    for (int i = 0; i < resp_wait; i++) begin
      tick();
      checkOutput("held resp vld", 512'({ic_resp_vld_o, dc_resp_vld_o}), own ? 512'(1) : 512'(2));
      checkOutput("held resp rdata", own ? dc_resp_rdata_o : ic_resp_rdata_o, rdata);
      checkOutput("held resp err", 512'(own ? dc_resp_err_o : ic_resp_err_o), 512'(err));
    end
    if (own) dc_resp_rdy_i = 1'b1; else ic_resp_rdy_i = 1'b1;
    tick();
    ic_resp_rdy_i = 1'b0;
    dc_resp_rdy_i = 1'b0;
    checkOutput("back to idle", 512'(busy_o), 512'(0));
  endtask

  // Waits (bounded) until the given requester's rdy is high, then takes the accept edge.
  task automatic acceptFrom(input logic own);
    int n = 0;
    #1;
    while (!(own ? dc_req_rdy_o : ic_req_rdy_o) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) checkOutput("accept timeout", 512'(0), 512'(1));
    tick();
    if (own) dc_req_vld_i = 1'b0; else ic_req_vld_i = 1'b0;
    checkOutput("owner after accept", 512'(owner_o), 512'(own));
  endtask

  task automatic applyStimulus(input logic own, input logic rd, input logic [63:0] addr, input logic [511:0] wdata,
                               input logic [511:0] rdata, input logic err, input int biu_wait, input int resp_wait);
    logic [63:0] aligned = addr & ~64'h3F;
    exp_req.push_back('{rd: rd, addr: aligned, wdata: wdata});
    exp_resp.push_back('{owner: own, rdata: rdata, err: err});
    if (own) begin
      dc_req_vld_i = 1'b1; dc_req_rd_i = rd; dc_req_addr_i = addr; dc_req_wdata_i = wdata;
    end else begin
      ic_req_vld_i = 1'b1; ic_req_rd_i = rd; ic_req_addr_i = addr; ic_req_wdata_i = wdata;
    end
    acceptFrom(own);
    serve(own, rd, aligned, wdata, rdata, err, biu_wait, resp_wait);
  endtask

  // Both requesters held valid; grants must alternate starting with DC.
  task automatic contend(input int rounds);
    logic own;
    logic [511:0] rd_data;
    ic_req_vld_i = 1'b1; ic_req_rd_i = 1'b1; ic_req_addr_i = 64'h2010; ic_req_wdata_i = '0;
    dc_req_vld_i = 1'b1; dc_req_rd_i = 1'b1; dc_req_addr_i = 64'h3020; dc_req_wdata_i = '0;
    for (int i = 0; i < rounds; i++) begin
      int n = 0;
      own = (i % 2 == 0);
      rd_data = {16{32'hC0DE_0000 + 32'(i)}};
      exp_req.push_back('{rd: 1'b1, addr: own ? 64'h3000 : 64'h2000, wdata: '0});
      exp_resp.push_back('{owner: own, rdata: rd_data, err: 1'b0});
      #1;
      while (!(ic_req_rdy_o || dc_req_rdy_o) && n < 50) begin
        tick();
        n++;
      end
      checkOutput("grant dc", 512'(dc_req_rdy_o), 512'(own));
      checkOutput("grant ic", 512'(ic_req_rdy_o), 512'(!own));
      tick();
      checkOutput("contend owner", 512'(owner_o), 512'(own));
      serve(own, 1'b1, own ? 64'h3000 : 64'h2000, '0, rd_data, 1'b0, 0, 0);
    end
    ic_req_vld_i = 1'b0;
    dc_req_vld_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    ic_req_vld_i = 0; ic_req_rd_i = 0; ic_req_addr_i = '0; ic_req_wdata_i = '0; ic_resp_rdy_i = 0;
    dc_req_vld_i = 0; dc_req_rd_i = 0; dc_req_addr_i = '0; dc_req_wdata_i = '0; dc_resp_rdy_i = 0;
    biu_req_rdy_i = 0; biu_resp_vld_i = 0; biu_resp_rdata_i = '0; biu_resp_err_i = 0;
    repeat (3) tick();
    checkOutput("reset busy", 512'(busy_o), 512'(0));
    checkOutput("reset owner", 512'(owner_o), 512'(0));
    checkOutput("reset spurious", 512'(spurious_resp_o), 512'(0));
    checkOutput("reset biu_req_vld", 512'(biu_req_vld_o), 512'(0));
    checkOutput("reset biu_req_addr", 512'(biu_req_addr_o), 512'(0));
    checkOutput("reset biu_resp_rdy", 512'(biu_resp_rdy_o), 512'(0));
    checkOutput("reset resp vld", 512'({ic_resp_vld_o, dc_resp_vld_o}), 512'(0));
    checkOutput("reset resp rdata", ic_resp_rdata_o, '0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("[TB] IC alone read");
    applyStimulus(1'b0, 1'b1, 64'h8000_1234, '0, {64{8'hA5}}, 1'b0, 0, 0);

    $display("[TB] both valid, alternating grants");
    contend(4);

    $display("[TB] DC write with BIU stall");
    applyStimulus(1'b1, 1'b0, 64'h1000_0040, {8{64'h0123_4567_89AB_CDEF}}, {64{8'h11}}, 1'b0, 5, 0);

    $display("[TB] response back-pressure with error");
    applyStimulus(1'b0, 1'b1, 64'h4000_007F, '0, {16{32'h5A5A_F00D}}, 1'b1, 0, 4);

    $display("[TB] spurious responses");
    biu_resp_vld_i = 1'b1; biu_resp_rdata_i = {64{8'h3C}}; biu_resp_err_i = 1'b0;
    tick();
    biu_resp_vld_i = 1'b0; biu_resp_rdata_i = '0;
    checkOutput("idle pulse busy", 512'(busy_o), 512'(0));
    checkOutput("idle pulse spurious", 512'(spurious_resp_o), 512'(1));
    checkOutput("idle pulse buffer", ic_resp_rdata_o, {16{32'h5A5A_F00D}});
    checkOutput("idle pulse err", 512'(ic_resp_err_o), 512'(1));
    exp_req.push_back('{rd: 1'b1, addr: 64'h7700, wdata: '0});
    exp_resp.push_back('{owner: 1'b0, rdata: {64{8'h77}}, err: 1'b0});
    ic_req_vld_i = 1'b1; ic_req_rd_i = 1'b1; ic_req_addr_i = 64'h7708; ic_req_wdata_i = '0;
    acceptFrom(1'b0);
    biu_resp_vld_i = 1'b1; biu_resp_rdata_i = {64{8'h3C}};
    tick();
    biu_resp_vld_i = 1'b0; biu_resp_rdata_i = '0;
    checkOutput("issue pulse stays issue", 512'(biu_req_vld_o), 512'(1));
    checkOutput("issue pulse no resp_rdy", 512'(biu_resp_rdy_o), 512'(0));
    serve(1'b0, 1'b1, 64'h7700, '0, {64{8'h77}}, 1'b0, 0, 0);
    checkOutput("spurious sticky", 512'(spurious_resp_o), 512'(1));

    $display("[TB] reset during WAIT");
    exp_req.push_back('{rd: 1'b0, addr: 64'h1000_0080, wdata: {16{32'hFACE_0001}}});
    dc_req_vld_i = 1'b1; dc_req_rd_i = 1'b0; dc_req_addr_i = 64'h1000_0095; dc_req_wdata_i = {16{32'hFACE_0001}};
    acceptFrom(1'b1);
    biu_req_rdy_i = 1'b1;
    tick();
    biu_req_rdy_i = 1'b0;
    checkOutput("in wait", 512'(biu_resp_rdy_o), 512'(1));
    rst_n = 1'b0;
    #1;
    checkOutput("async rst biu_resp_rdy", 512'(biu_resp_rdy_o), 512'(0));
    checkOutput("async rst busy", 512'(busy_o), 512'(0));
    checkOutput("async rst owner", 512'(owner_o), 512'(0));
    checkOutput("async rst spurious", 512'(spurious_resp_o), 512'(0));
    checkOutput("async rst biu addr", 512'(biu_req_addr_o), 512'(0));
    checkOutput("async rst biu wdata", biu_req_wdata_o, '0);
    checkOutput("async rst resp vld", 512'({ic_resp_vld_o, dc_resp_vld_o}), 512'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    contend(1);
    applyStimulus(1'b0, 1'b1, 64'h9000_00C4, '0, {32{16'hBEEF}}, 1'b0, 1, 1);

    repeat (3) tick();
    checkOutput("req queue drained", 512'(exp_req.size()), 512'(0));
    checkOutput("resp queue drained", 512'(exp_resp.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
